// File: rtl/z80_uart_port.sv
// z80_uart_fifo: small synchronous FIFO with a combinational head (first-word fall-through).
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: a push to a full FIFO is dropped unless a pop happens that cycle; a pop on empty is ignored.
module z80_uart_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle leave the occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array, deliberately not reset: occupancy is governed by the pointers only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// z80_uart_port: I/O-mapped 8N1 UART for the tv80n bus with TX/RX FIFOs and a polled status register.
// Latency: TX push on the first strobe cycle, start bit one cycle later; RX pop/flag clear one cycle after the read ends.
// Backpressure: writes to a full TX FIFO are dropped silently; RX bytes arriving to a full FIFO set the sticky ovr flag.
module z80_uart_port #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] DATA_ADDR    = 8'hBB,
  parameter logic [7:0] STAT_ADDR    = 8'hBC,
  parameter int         FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] address,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       sel,
  output logic       tx,
  input  logic       rx
);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

  // Bus decode
  logic wr_hit, rd_data_hit, rd_stat_hit;
  logic wr_hit_q, rd_data_q, rd_stat_q;
  logic tx_push, rx_pop, stat_clr;

  // FIFO interfaces
  logic [7:0] tx_head, rx_head;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_pop;

  // TX engine
  uart_st_t     tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  // RX engine
  logic          rx_s1, rx_s2;
  uart_st_t      rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_stop_smp, rx_push, ovr_set, ferr_set;

  // Sticky status flags
  logic ovr, ferr;
  logic tx_idle;
  logic [7:0] status;

  assign wr_hit      = !iorq_n && !wr_n && (address == DATA_ADDR);
  assign rd_data_hit = !iorq_n && !rd_n && (address == DATA_ADDR);
  assign rd_stat_hit = !iorq_n && !rd_n && (address == STAT_ADDR);
  assign sel         = rd_data_hit || rd_stat_hit;

  // Write acts on the leading edge; reads act after the trailing edge so the byte is stable for the whole cycle.
  assign tx_push  = wr_hit && !wr_hit_q;
  assign rx_pop   = rd_data_q && !rd_data_hit;
  assign stat_clr = rd_stat_q && !rd_stat_hit;

  assign tx_idle = tx_empty && (tx_st == S_IDLE);
  assign status  = {3'b000, ferr, ovr, tx_idle, !tx_full, !rx_empty};

  // Read mux: an empty RX FIFO reads as zero rather than stale storage.
  always_comb begin
    dbus_out = 8'h00;
    if (rd_data_hit)      dbus_out = rx_empty ? 8'h00 : rx_head;
    else if (rd_stat_hit) dbus_out = status;
  end

  // Registered strobe copies for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_hit_q  <= 1'b0;
      rd_data_q <= 1'b0;
      rd_stat_q <= 1'b0;
    end else begin
      wr_hit_q  <= wr_hit;
      rd_data_q <= rd_data_hit;
      rd_stat_q <= rd_stat_hit;
    end
  end

  z80_uart_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .pop     (tx_pop),
    .din     (dbus_in),
    .dout    (tx_head),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  z80_uart_fifo #(.AW(FIFO_AW), .W(8)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .din     (rx_shift),
    .dout    (rx_head),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  // The shifter loads from IDLE, or directly at the end of STOP so back-to-back frames have no idle gap.
  assign tx_pop = !tx_empty && ((tx_st == S_IDLE) || ((tx_st == S_STOP) && (tx_cnt == LAST)));

  // TX frame sequencer with a registered line output (idle high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st    <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx       <= 1'b1;
    end else begin
      case (tx_st)
        S_IDLE: begin
          tx <= 1'b1;
          if (!tx_empty) begin
            tx_shift <= tx_head;
            tx_cnt   <= '0;
            tx       <= 1'b0;
            tx_st    <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_bit <= 3'd0;
            tx     <= tx_shift[0];
            tx_st  <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx    <= 1'b1;
              tx_st <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (!tx_empty) begin
              tx_shift <= tx_head;
              tx       <= 1'b0;
              tx_st    <= S_START;
            end else begin
              tx_st <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous rx line; resets to the idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  assign rx_stop_smp = (rx_st == S_STOP) && (rx_cnt == LAST);
  assign rx_push     = rx_stop_smp && rx_s2;
  assign ferr_set    = rx_stop_smp && !rx_s2;
  // A CPU pop in the same cycle frees a slot, so the byte is accepted and no overrun is flagged.
  assign ovr_set     = rx_push && rx_full && !rx_pop;

  // RX frame sequencer: mid-bit sampling, half-bit start qualification to reject glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st    <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      case (rx_st)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s2) rx_st <= S_START;
        end
        S_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt <= '0;
            rx_bit <= 3'd0;
            rx_st  <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            rx_st  <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (ovr_set)       ovr <= 1'b1;
      else if (stat_clr) ovr <= 1'b0;
      if (ferr_set)      ferr <= 1'b1;
      else if (stat_clr) ferr <= 1'b0;
    end
  end
endmodule
